processing_element: RTL and testbench
=====================================

# processing_element

IEEE-754 single-precision multiply-accumulate processing element for a linear systolic array. Each accepted transaction multiplies operand `a` by either the incoming `b` or a `b` word held in a small local memory. It accumulates the products into `c` and forwards `a` and `b` to the next PE through a strobe/acknowledge handshake.

## Interface
- `ADDR_W`, default 2: local b-memory address width; memory holds 2^ADDR_W 32-bit words.
- `ACC_LEN`, default 1: number of products summed before `c` is published (≥1).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `a`  in  32  float operand A.
- `b`  in  32  float operand B.
- `stb`  in  1  upstream offers `a`/`b`.
- `input_ack`  out  1  PE can accept this cycle.
- `input_b_valid`  in  1  `b` carries valid data.
- `mem_select`  in  1  0 = use/store live `b`; 1 = use `mem[addr]`.
- `addr`  in  ADDR_W  local memory address.
- `next_PE_ack`  in  1  downstream accepts `output_a`/`output_b`.
- `output_a`  out  32  registered copy of accepted `a`.
- `output_b`  out  32  registered copy of accepted `b`.
- `output_b_valid`  out  1  registered copy of accepted `input_b_valid`.
- `output_stb`  out  1  forwarded data pending for downstream.
- `c`  out  32  last published accumulation result.

## Operation
- Accept condition: `stb && input_ack` at a rising edge.
- FSM has three states:
  - IDLE: `input_ack` = (state==IDLE) && (!`output_stb` || `next_PE_ack`). On accept, go to MUL.
  - MUL: product P = `a` × operand B is computed and registered. Go to ACC.
  - ACC: acc + P is computed.
    - If count == ACC_LEN-1: `c` <= sum, acc <= 0, count <= 0.
    - Else: acc <= sum, count++.
    - Go to IDLE.
- Operand B = (`mem_select`==0 && `input_b_valid`) ? `b` : `mem[addr]`. It is captured at accept.
- Memory write: on accept with `mem_select`==0 and `input_b_valid`=1, `mem[addr]` <= `b`.
- Forwarding: on accept, `output_a` <= `a`, `output_b` <= `b`, `output_b_valid` <= `input_b_valid`, `output_stb` <= 1. These are independent of `mem_select`.
- `output_stb` clears at an edge where `output_stb && next_PE_ack` and no new accept occurs. A new accept in the same cycle reloads the outputs and keeps `output_stb`=1.
- Arithmetic (multiply and add): round-to-nearest-even.
  - Subnormal inputs are treated as signed zero.
  - A result underflowing the normal range is signed zero.
  - Overflow gives ±Inf.
  - Any NaN input, Inf×0, or Inf−Inf gives 0x7FC00000.
  - Other Inf inputs propagate as Inf.
  - Exact-zero sum gives +0.

## Timing
- Reset (synchronous): all outputs are 0. FSM goes to IDLE, acc=0, count=0, all memory words = 0. Reset dominates any concurrent accept or handshake.
- `input_ack` is combinational from state, `output_stb`, and `next_PE_ack`. It is 1 in the first cycle after reset release.
- Latency: accept at edge E0 → product at E1 → `c` updated at E2 (when the group completes). `output_*` are valid after E0.
- Throughput: one transaction per 3 cycles.
- `c` holds its value between publications.
- Downstream stall: while `output_stb`=1 and `next_PE_ack`=0, `input_ack`=0 and the forwarded outputs are stable.
- `addr`, `mem_select`, and `b` are sampled only at the accept edge.
- A read and a write to the same `addr` on one accept use the live `b`, so no hazard exists.

## Test plan
- Reset release; `stb`=1, `next_PE_ack`=1, `input_b_valid`=1, `mem_select`=0, `addr`=0, `a`=`b`=0x3F800000:
  - `input_ack`=1 and accept on the first edge.
  - `output_a`=0x3F800000 and `output_stb`=1 after that edge.
  - `c`=0x3F800000 two edges later.
  - `mem[0]`=0x3F800000.
- `a`=0x40000000, `b`=0x40400000 → `c`=0x40C00000. `a`=0xBFC00000, `b`=0x40000000 → `c`=0xC0400000.
- Memory path:
  - Load `b`=0x3F000000 at `addr`=1 with `mem_select`=0.
  - Then `mem_select`=1, `addr`=1, `a`=0x40800000, `input_b_valid`=0 → `c`=0x40000000.
- Backpressure: `next_PE_ack`=0 after the first accept → `output_stb` stays 1, `input_ack`=0, and no second accept. Raising `next_PE_ack` restores `input_ack` in the same cycle.
- With ACC_LEN=2: products 1.0 and 2.0 → `c` unchanged after the first product and 0x40400000 after the second. The next group restarts from 0.
- Assert `rst` in state MUL → next cycle all outputs 0, FSM in IDLE, and `c` never publishes the aborted product.

Source files
------------

// File: rtl/processing_element_if.sv
// processing_element_if: operand, forwarding and result signals of one systolic PE
interface processing_element_if #(
  parameter int ADDR_W = 2
);
  logic [31:0] a;
  logic [31:0] b;
  logic stb;
  logic input_ack;
  logic input_b_valid;
  logic mem_select;
  logic [ADDR_W-1:0] addr;
  logic next_PE_ack;
  logic [31:0] output_a;
  logic [31:0] output_b;
  logic output_b_valid;
  logic output_stb;
  logic [31:0] c;
  modport master (
    output a, b, stb, input_b_valid, mem_select, addr, next_PE_ack,
    input input_ack, output_a, output_b, output_b_valid, output_stb, c
  );
  modport slave (
    input a, b, stb, input_b_valid, mem_select, addr, next_PE_ack,
    output input_ack, output_a, output_b, output_b_valid, output_stb, c
  );
endinterface

// File: rtl/processing_element.sv
// processing_element: fp32 multiply-accumulate PE with local b-memory and a/b forwarding
module processing_element #(
  parameter int ADDR_W = 2,
  parameter int ACC_LEN = 1
) (
  input logic clk,
  input logic rst,
  processing_element_if.slave pe
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL = 2'd1;
  localparam logic [1:0] ACC = 2'd2;
  localparam logic [31:0] QNAN = 32'h7fc00000;
  function automatic logic [31:0] fpack(input logic s, input logic signed [9:0] e, input logic [23:0] m, input logic g, input logic st);
    logic [24:0] r;
    logic signed [9:0] f;
    r = {1'b0, m} + 25'(g && (st || m[0]));
    f = e + $signed({9'd0, r[24]});
    return f > 10'sd254 ? {s, 8'hff, 23'd0} : f < 10'sd1 ? {s, 31'd0} : {s, f[7:0], r[24] ? r[23:1] : r[22:0]};
  endfunction
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic s, xz, yz, xi, yi, xn, yn;
    logic [47:0] p;
    logic signed [9:0] e;
    s = x[31] ^ y[31];
    xz = x[30:23] == 8'd0;
    yz = y[30:23] == 8'd0;
    xi = &x[30:23] && x[22:0] == 23'd0;
    yi = &y[30:23] && y[22:0] == 23'd0;
    xn = &x[30:23] && |x[22:0];
    yn = &y[30:23] && |y[22:0];
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = $signed(10'(x[30:23]) + 10'(y[30:23]) - 10'd127);
    if (xn || yn || (xi && yz) || (yi && xz)) return QNAN;
    if (xi || yi) return {s, 8'hff, 23'd0};
    if (xz || yz) return {s, 31'd0};
    return p[47] ? fpack(s, e + 10'sd1, p[47:24], p[23], |p[22:0]) : fpack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic xz, yz, xi, yi, xn, yn;
    logic [31:0] bg, sm;
    logic [7:0] d;
    logic [53:0] w;
    logic [26:0] mb, ms, n;
    logic [27:0] sum;
    logic signed [9:0] e;
    xz = x[30:23] == 8'd0;
    yz = y[30:23] == 8'd0;
    xi = &x[30:23] && x[22:0] == 23'd0;
    yi = &y[30:23] && y[22:0] == 23'd0;
    xn = &x[30:23] && |x[22:0];
    yn = &y[30:23] && |y[22:0];
    if (xn || yn || (xi && yi && x[31] != y[31])) return QNAN;
    if (xi) return {x[31], 8'hff, 23'd0};
    if (yi) return {y[31], 8'hff, 23'd0};
    if (xz && yz) return 32'd0;
    if (xz) return y;
    if (yz) return x;
    {bg, sm} = x[30:0] >= y[30:0] ? {x, y} : {y, x};
    d = bg[30:23] - sm[30:23];
    w = {1'b1, sm[22:0], 30'd0} >> (d > 8'd31 ? 8'd31 : d);
    mb = {1'b1, bg[22:0], 3'd0};
    ms = w[53:27] | 27'(|w[26:0]);
    sum = bg[31] ^ sm[31] ? {1'b0, mb} - {1'b0, ms} : {1'b0, mb} + {1'b0, ms};
    if (sum == 28'd0) return 32'd0;
    e = $signed({2'b0, bg[30:23]});
    n = sum[26:0];
    if (sum[27]) begin
      n = sum[27:1] | 27'(sum[0]);
      e = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!n[26]) begin
          n = n << 1;
          e = e - 10'sd1;
        end
      end
    end
    return fpack(bg[31], e, n[26:3], n[2], |n[1:0]);
  endfunction
  logic [1:0] state;
  logic [31:0] op_a, op_b, prod, acc, sum;
  logic [15:0] cnt;
  logic [31:0] mem [2**ADDR_W];
  logic accept, use_b;
  assign pe.input_ack = state == IDLE && (!pe.output_stb || pe.next_PE_ack);
  assign accept = pe.stb && pe.input_ack;
  assign use_b = !pe.mem_select && pe.input_b_valid;
  assign sum = fadd(acc, prod);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a <= 32'd0;
      op_b <= 32'd0;
      prod <= 32'd0;
      acc <= 32'd0;
      cnt <= 16'd0;
      pe.output_a <= 32'd0;
      pe.output_b <= 32'd0;
      pe.output_b_valid <= 1'b0;
      pe.output_stb <= 1'b0;
      pe.c <= 32'd0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 32'd0;
    end else begin
      state <= state == IDLE ? (accept ? MUL : IDLE) : state == MUL ? ACC : IDLE;
      if (accept) begin
        op_a <= pe.a;
        op_b <= use_b ? pe.b : mem[pe.addr];
        pe.output_a <= pe.a;
        pe.output_b <= pe.b;
        pe.output_b_valid <= pe.input_b_valid;
        pe.output_stb <= 1'b1;
        if (use_b) mem[pe.addr] <= pe.b;
      end else if (pe.next_PE_ack) begin
        pe.output_stb <= 1'b0;
      end
      if (state == MUL) prod <= fmul(op_a, op_b);
      if (state == ACC) begin
        if (cnt == 16'(ACC_LEN - 1)) begin
          pe.c <= sum;
          acc <= 32'd0;
          cnt <= 16'd0;
        end else begin
          acc <= sum;
          cnt <= cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_processing_element.sv
// tb_processing_element: scoreboard bench for two PEs (ACC_LEN 1 and 2) sharing one stimulus stream
module tb_processing_element;
  typedef struct {
    logic [31:0] a, b;
    logic bv;
    logic [31:0] c1, c2;
  } exp_t;
  typedef struct {
    logic [31:0] a, b;
    logic bv, ms;
    logic [1:0] ad;
    logic [31:0] c1, c2;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  processing_element_if #(.ADDR_W(2)) pif ();
  processing_element_if #(.ADDR_W(2)) pif2 ();
  assign pif2.a = pif.a;
  assign pif2.b = pif.b;
  assign pif2.stb = pif.stb;
  assign pif2.input_b_valid = pif.input_b_valid;
  assign pif2.mem_select = pif.mem_select;
  assign pif2.addr = pif.addr;
  assign pif2.next_PE_ack = pif.next_PE_ack;
  processing_element #(.ADDR_W(2), .ACC_LEN(1)) dut (.clk(clk), .rst(rst), .pe(pif));
  processing_element #(.ADDR_W(2), .ACC_LEN(2)) dut2 (.clk(clk), .rst(rst), .pe(pif2));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask
  task automatic send(input vec_t v, output int waited);
    sb.push_back('{v.a, v.b, v.bv, v.c1, v.c2});
    pif.a = v.a;
    pif.b = v.b;
    pif.input_b_valid = v.bv;
    pif.mem_select = v.ms;
    pif.addr = v.ad;
    pif.stb = 1'b1;
    waited = 0;
    while (!pif.input_ack && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("accept_timeout", 32'(pif.input_ack), 32'd1);
    @(posedge clk);
    #1 pif.stb = 1'b0;
  endtask
  initial begin
    bit pend;
    int ph;
    exp_t cur;
    pend = 0;
    ph = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          ph++;
          if (ph == 1) begin
            chk("fwd_a", pif.output_a, cur.a);
            chk("fwd_b", pif.output_b, cur.b);
            chk("fwd_bv", 32'(pif.output_b_valid), 32'(cur.bv));
            chk("fwd_stb", 32'(pif.output_stb), 32'd1);
            chk("fwd_a_acc2", pif2.output_a, cur.a);
          end
          if (ph == 3) begin
            chk("c_acc1", pif.c, cur.c1);
            chk("c_acc2", pif2.c, cur.c2);
            pend = 0;
          end
        end
        if (!pend && pif.stb && pif.input_ack) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got accept expected none at %0t", $time);
          end else begin
            cur = sb.pop_front();
            pend = 1;
            ph = 0;
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vt[$];
    int w;
    vt.push_back('{32'h40800000, 32'h3F000000, 1'b1, 1'b0, 2'd1, 32'h40000000, 32'h40400000});
    vt.push_back('{32'h40000000, 32'h40400000, 1'b1, 1'b0, 2'd2, 32'h40C00000, 32'h40400000});
    vt.push_back('{32'h40800000, 32'hDEADBEEF, 1'b0, 1'b1, 2'd1, 32'h40000000, 32'h41000000});
    vt.push_back('{32'hBFC00000, 32'h40000000, 1'b1, 1'b0, 2'd3, 32'hC0400000, 32'h41000000});
    vt.push_back('{32'h3F800000, 32'h40400000, 1'b1, 1'b0, 2'd3, 32'h40400000, 32'h00000000});
    vt.push_back('{32'h40000000, 32'h12345678, 1'b1, 1'b1, 2'd0, 32'h40000000, 32'h00000000});
    vt.push_back('{32'h7F800000, 32'h00000000, 1'b1, 1'b0, 2'd2, 32'h7FC00000, 32'h7FC00000});
    vt.push_back('{32'h7F000000, 32'h40000000, 1'b1, 1'b0, 2'd3, 32'h7F800000, 32'h7FC00000});
    vt.push_back('{32'h3F800000, 32'hFF800000, 1'b1, 1'b0, 2'd3, 32'hFF800000, 32'h7FC00000});
    vt.push_back('{32'h00400000, 32'h3F800000, 1'b1, 1'b0, 2'd0, 32'h00000000, 32'h7FC00000});
    vt.push_back('{32'h00800000, 32'h3F000000, 1'b1, 1'b0, 2'd0, 32'h00000000, 32'h00000000});
    vt.push_back('{32'h3F800001, 32'h3F800001, 1'b1, 1'b0, 2'd0, 32'h3F800002, 32'h00000000});
    vt.push_back('{32'h3F800000, 32'h33800000, 1'b1, 1'b0, 2'd0, 32'h33800000, 32'h3F800002});
    rst = 1'b1;
    pif.stb = 1'b0;
    pif.a = 32'd0;
    pif.b = 32'd0;
    pif.input_b_valid = 1'b0;
    pif.mem_select = 1'b0;
    pif.addr = 2'd0;
    pif.next_PE_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_output_a", pif.output_a, 32'd0);
    chk("rst_output_b", pif.output_b, 32'd0);
    chk("rst_output_b_valid", 32'(pif.output_b_valid), 32'd0);
    chk("rst_output_stb", 32'(pif.output_stb), 32'd0);
    chk("rst_c", pif.c, 32'd0);
    chk("rst_c_acc2", pif2.c, 32'd0);
    chk("rst_input_ack", 32'(pif.input_ack), 32'd1);
    pif.next_PE_ack = 1'b0;
    send('{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 2'd0, 32'h3F800000, 32'h00000000}, w);
    chk("first_edge_accept", 32'(w), 32'd0);
    pif.a = vt[0].a;
    pif.b = vt[0].b;
    pif.stb = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_output_stb", 32'(pif.output_stb), 32'd1);
      chk("stall_input_ack", 32'(pif.input_ack), 32'd0);
      chk("stall_output_a", pif.output_a, 32'h3F800000);
    end
    @(posedge clk);
    #1 pif.next_PE_ack = 1'b1;
    #1 chk("ack_restore", 32'(pif.input_ack), 32'd1);
    foreach (vt[i]) send(vt[i], w);
    send('{32'h40400000, 32'h40400000, 1'b1, 1'b0, 2'd0, 32'h41100000, 32'h00000000}, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_output_a", pif.output_a, 32'd0);
    chk("abort_output_b", pif.output_b, 32'd0);
    chk("abort_output_b_valid", 32'(pif.output_b_valid), 32'd0);
    chk("abort_output_stb", 32'(pif.output_stb), 32'd0);
    chk("abort_c", pif.c, 32'd0);
    chk("abort_c_acc2", pif2.c, 32'd0);
    chk("abort_input_ack", 32'(pif.input_ack), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_publish", pif.c, 32'd0);
      chk("abort_no_publish_acc2", pif2.c, 32'd0);
    end
    @(posedge clk);
    #1;
    send('{32'h3F800000, 32'h00000000, 1'b0, 1'b1, 2'd1, 32'h00000000, 32'h00000000}, w);
    send('{32'h3F800000, 32'h40000000, 1'b1, 1'b0, 2'd0, 32'h40000000, 32'h40000000}, w);
    repeat (5) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
